// File: rtl/vga_vtiming.sv
// Vertical timing generator: counts lines from an upstream HS and drives VS/line_cnt.
// Optional macro VGA_VTIMING_WATCHDOG_EN adds a loss-of-HS watchdog that drops lock.
module vga_vtiming #(
    parameter int   LINE_MAX = 525,
    parameter int   VS_FP    = 10,
    parameter int   VS_BP    = 12,
    parameter logic VS_POL   = 1'b1,
    parameter logic HS_POL   = 1'b1,
    parameter int   TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs_in,
    output logic        VS,
    output logic [11:0] line_cnt,
    output logic        line_tick,
    output logic        frame_start,
    output logic        locked,
    output logic        lost
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [11:0] LAST_LINE = 12'(LINE_MAX - 1);
    localparam logic [11:0] VS_START  = 12'(VS_FP);
    localparam logic [11:0] VS_END    = 12'(VS_BP);

    state_t      state_q, state_d;
    logic        hs_q1, hs_q2;
    logic        evt_s;
    logic        evt_q;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic        vs_q, vs_d;
    logic        tick_q;
    logic        fs_q, fs_d;
    logic        locked_q;
    logic        lost_q, lost_d;
    logic        expire_s;

    assign evt_s = (hs_q1 == HS_POL) && (hs_q2 != HS_POL);

    // HS synchroniser and event register; reset flushes any edge seen during reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            hs_q1 <= ~HS_POL;
            hs_q2 <= ~HS_POL;
            evt_q <= 1'b0;
        end else begin
            hs_q1 <= hs_in;
            hs_q2 <= hs_q1;
            evt_q <= evt_s;
        end
    end

`ifdef VGA_VTIMING_WATCHDOG_EN
    localparam int             WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_q, wd_d;

    assign expire_s = (state_q == LOCKED) && !evt_q && (wd_q == WD_LAST);

    // Watchdog next value: counts idle cycles while locked, an event always wins
    always_comb begin
        wd_d = '0;
        if (state_q == LOCKED && !evt_q && !expire_s) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = '0;
        end
    end

    // Watchdog register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // Line-counting FSM next state and registered-output next values
    always_comb begin
        state_d    = state_q;
        line_cnt_d = line_cnt_q;
        fs_d       = 1'b0;
        lost_d     = 1'b0;
        case (state_q)
            SEARCH: begin
                line_cnt_d = 12'd0;
                if (evt_q) begin
                    state_d = LOCKED;
                    fs_d    = 1'b1;
                end else begin
                    state_d = SEARCH;
                end
            end
            LOCKED: begin
                if (evt_q) begin
                    if (line_cnt_q >= LAST_LINE) begin
                        line_cnt_d = 12'd0;
                        fs_d       = 1'b1;
                    end else begin
                        line_cnt_d = line_cnt_q + 12'd1;
                    end
                end else if (expire_s) begin
                    state_d    = SEARCH;
                    line_cnt_d = 12'd0;
                    lost_d     = 1'b1;
                end else begin
                    line_cnt_d = line_cnt_q;
                end
            end
            default: begin
                state_d    = SEARCH;
                line_cnt_d = 12'd0;
            end
        endcase

        // VS follows the new line index so both change on the same edge
        if (state_d == LOCKED && line_cnt_d >= VS_START && line_cnt_d < VS_END) begin
            vs_d = VS_POL;
        end else begin
            vs_d = ~VS_POL;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= SEARCH;
            line_cnt_q <= 12'd0;
            vs_q       <= ~VS_POL;
            tick_q     <= 1'b0;
            fs_q       <= 1'b0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_cnt_q <= line_cnt_d;
            vs_q       <= vs_d;
            tick_q     <= evt_q;
            fs_q       <= fs_d;
            locked_q   <= (state_d == LOCKED);
            lost_q     <= lost_d;
        end
    end

    assign VS          = vs_q;
    assign line_cnt    = line_cnt_q;
    assign line_tick   = tick_q;
    assign frame_start = fs_q;
    assign locked      = locked_q;
    assign lost        = lost_q;

endmodule

// File: doc/vga_vtiming.md
VGA_VTIMING -- requirements
Module: vga_vtiming

Interface
REQ-001 SHALL have parameter LINE_MAX, default 525, lines per frame (>=2).
REQ-002 SHALL have parameter VS_FP, default 10, line index where VS becomes active.
REQ-003 SHALL have parameter VS_BP, default 12, line index where VS becomes inactive; VS_FP < VS_BP <= LINE_MAX.
REQ-004 SHALL have parameter VS_POL, default 1'b1, active level of VS.
REQ-005 SHALL have parameter HS_POL, default 1'b1, active level of hs_in.
REQ-006 SHALL have parameter TIMEOUT, default 4096, watchdog limit in clk cycles.
REQ-007 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, reset, synchronous and active-high despite the name.
REQ-009 SHALL have port hs_in, input, 1, horizontal sync from the upstream HS generator, synchronous to clk.
REQ-010 SHALL have port VS, output, 1, vertical sync.
REQ-011 SHALL have port line_cnt, output, 12, current line index.
REQ-012 SHALL have port line_tick, output, 1, one-cycle pulse per detected line start.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse at line 0.
REQ-014 SHALL have port locked, output, 1, high while in state LOCKED.
REQ-015 SHALL have port lost, output, 1, one-cycle pulse on watchdog expiry.

Function
REQ-016 SHALL register hs_in into hs_q1, then hs_q2; the line start event is hs_q1==HS_POL and hs_q2!=HS_POL.
REQ-017 SHALL make line_tick a registered output, high exactly one cycle, 2 cycles after the clk edge that first samples hs_in at HS_POL.
REQ-018 SHALL implement a two-state FSM, SEARCH and LOCKED; reset enters SEARCH.
REQ-019 In SEARCH, an event SHALL set line_cnt=0, pulse frame_start, and enter LOCKED in the same cycle as line_tick.
REQ-020 In LOCKED, each event SHALL increment line_cnt; at LINE_MAX-1 it SHALL wrap to 0 and pulse frame_start coincident with line_tick.
REQ-021 Line_cnt SHALL change only on an event and never exceed LINE_MAX-1.
REQ-022 VS SHALL be registered and equal VS_POL when line_cnt is in [VS_FP, VS_BP) in LOCKED, else ~VS_POL; it updates in the same cycle as line_cnt.
REQ-023 In SEARCH, VS SHALL equal ~VS_POL and line_cnt SHALL equal 0.
REQ-024 Locked SHALL be 1 exactly when the state is LOCKED.
REQ-025 A hs_in held constant SHALL produce no events; a pulse of one cycle at HS_POL SHALL produce exactly one event.

Reset
REQ-026 While rst_n=1 at a clk edge: VS=~VS_POL, line_cnt=0, line_tick=0, frame_start=0, locked=0, lost=0, hs_q1=hs_q2=~HS_POL, watchdog=0, state SEARCH.
REQ-027 Reset asserted mid-frame SHALL abort immediately; after release the block SHALL re-lock on the next event.
REQ-028 An hs_in edge during the reset cycle SHALL not produce an event after release.

Configuration
REQ-029 Macro VGA_VTIMING_WATCHDOG_EN, when defined, SHALL add a cycle counter that clears on every event and increments otherwise while LOCKED.
REQ-030 With the macro defined, a counter reaching TIMEOUT-1 without an event SHALL pulse lost, enter SEARCH, force VS=~VS_POL and line_cnt=0 the next cycle.
REQ-031 With the macro defined, an event in the expiry cycle SHALL take priority: no lost pulse, counter cleared, state stays LOCKED.
REQ-032 Without the macro, the counter SHALL be absent, lost SHALL be tied to 0, and LOCKED SHALL be left only by reset.

Verification (LINE_MAX=8, VS_FP=2, VS_BP=4, VS_POL=1, HS_POL=1, TIMEOUT=64)
REQ-033 SHALL cover: reset, then hs_in pulses every 20 cycles -> first line_tick 2 cycles after the first sample, with frame_start=1, locked=1, line_cnt=0.
REQ-034 SHALL cover: 9 further pulses -> line_cnt 1..7,0,1; VS=1 only at lines 2,3; frame_start again at the wrap 7->0.
REQ-035 SHALL cover: hs_in held high for 5 cycles -> one line_tick only; hs_in held at 0 -> no ticks.
REQ-036 SHALL cover: rst_n=1 for one cycle at line 3 -> VS=0, line_cnt=0, locked=0; the next pulse re-locks at line 0.
REQ-037 SHALL cover, with the macro: pulses stop at line 5 -> lost pulses exactly 64 cycles after the last event; locked=0, VS=0; the next pulse re-locks.
REQ-038 SHALL cover, with the macro: event coincident with the expiry cycle -> no lost pulse, line_cnt increments; without the macro, the stop scenario -> lost stays 0 and locked stays 1.
